// File: rtl/uart_rx_fifo_if.sv
// Core-side port bundle of the UART receiver: FWFT byte stream plus sticky error flags.
// The receiver drives the master view and the consuming core uses the slave view.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rdata;
  logic                rvalid;
  logic                rready;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                frame_err;
  logic                clr_err;

  modport master (
    output rdata, rvalid, count, overrun, frame_err,
    input  rready, clr_err
  );

  modport slave (
    input  rdata, rvalid, count, overrun, frame_err,
    output rready, clr_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and sticky overrun/framing flags.
// The receiver never stalls: a byte arriving while the FIFO is full is dropped and flagged.
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_fifo_if.master bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT + 1);
  localparam logic [CNT_W-1:0]      HALF_END = CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0]      BIT_END  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, rxs_q;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  push_s, frame_ev_s;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic                  full_s, pop_s, push_ok_s, drop_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_IDLE: if (rxs_q) state_d = S_IDLE;      else state_d = S_WAIT_IDLE;
      S_IDLE:      if (!rxs_q) state_d = S_START;    else state_d = S_IDLE;
      S_START:     if (cyc_q == HALF_END) state_d = rxs_q ? S_IDLE : S_DATA;
                   else state_d = S_START;
      S_DATA:      if ((cyc_q == BIT_END) && (bit_q == 3'd7)) state_d = S_STOP;
                   else state_d = S_DATA;
      S_STOP:      if (cyc_q == BIT_END) state_d = rxs_q ? S_IDLE : S_WAIT_IDLE;
                   else state_d = S_STOP;
      default:     state_d = S_WAIT_IDLE;
    endcase
  end

  // Counter restarts at each sample point so every sample lands mid-bit.
  always_comb begin
    cyc_d      = cyc_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    push_s     = 1'b0;
    frame_ev_s = 1'b0;
    case (state_q)
      S_WAIT_IDLE, S_IDLE: begin
        cyc_d = '0;
        bit_d = 3'd0;
      end
      S_START: if (cyc_q == HALF_END) begin
        cyc_d = '0;
        bit_d = 3'd0;
      end else begin
        cyc_d = cyc_q + CNT_W'(1);
      end
      S_DATA: if (cyc_q == BIT_END) begin
        cyc_d   = '0;
        shift_d = {rxs_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end else begin
        cyc_d = cyc_q + CNT_W'(1);
      end
      S_STOP: if (cyc_q == BIT_END) begin
        cyc_d      = '0;
        push_s     = rxs_q;
        frame_ev_s = ~rxs_q;
      end else begin
        cyc_d = cyc_q + CNT_W'(1);
      end
      default: cyc_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // A push into a full FIFO still succeeds when the head is popped in the same cycle.
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    pop_s     = (count_q != '0) && bus.rready;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d  = pop_s ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    if (drop_s)           overrun_d = 1'b1;
    else if (bus.clr_err) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
    if (frame_ev_s)       frame_err_d = 1'b1;
    else if (bus.clr_err) frame_err_d = 1'b0;
    else                  frame_err_d = frame_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus.rvalid    = (count_q != '0);
  assign bus.rdata     = bus.rvalid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a 4-cycle half bit (8-cycle bit period).
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  logic rxd;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(.CLK_PER_HALF_BIT(4), .DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 80-cycle frame; pop_at >= 0 raises rready for exactly that cycle of the frame.
  task automatic send(input logic [7:0] b, input logic stop, input int pop_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      rxd = fr[c / 8];
      if (pop_at >= 0) bus.rready = (c == pop_at);
    end
    @(posedge clk);
    #1;
    rxd        = 1'b1;
    bus.rready = 1'b0;
    tick(4);
  endtask

  task automatic pop(input logic [7:0] exp, input string tag);
    chk(tag, bus.rdata, exp);
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rxd         = 1'b1;
    bus.rready  = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_flags", {bus.overrun, bus.frame_err}, 0);
    rst = 1'b0;
    tick(5);

    send(8'h55, 1'b1, -1);
    chk("t1_rvalid", bus.rvalid, 1);
    chk("t1_rdata", bus.rdata, 8'h55);
    chk("t1_count", bus.count, 1);
    chk("t1_flags", {bus.overrun, bus.frame_err}, 0);
    pop(8'h55, "t1_pop");
    chk("t1_count_after", bus.count, 0);
    chk("t1_rvalid_after", bus.rvalid, 0);

    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(24);
    chk("t2_count", bus.count, 0);
    chk("t2_rvalid", bus.rvalid, 0);
    chk("t2_flags", {bus.overrun, bus.frame_err}, 0);

    for (int i = 0; i < 17; i++) send(i[7:0], 1'b1, -1);
    chk("t3_count", bus.count, 16);
    chk("t3_overrun", bus.overrun, 1);
    chk("t3_frame_err", bus.frame_err, 0);
    chk("t3_rdata", bus.rdata, 8'h00);
    for (int i = 0; i < 16; i++) pop(i[7:0], "t3_pop");
    chk("t3_count_after", bus.count, 0);
    chk("t3_rvalid_after", bus.rvalid, 0);

    send(8'hA3, 1'b0, -1);
    chk("t4_frame_err", bus.frame_err, 1);
    chk("t4_count", bus.count, 0);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    chk("t4_clr_frame", bus.frame_err, 0);
    chk("t4_clr_overrun", bus.overrun, 0);
    send(8'h3C, 1'b1, -1);
    chk("t4_count_next", bus.count, 1);
    chk("t4_flags_next", {bus.overrun, bus.frame_err}, 0);
    pop(8'h3C, "t4_pop");

    for (int i = 0; i < 16; i++) send(8'h20 + i[7:0], 1'b1, -1);
    chk("t5_count_full", bus.count, 16);
    chk("t5_overrun_pre", bus.overrun, 0);
    send(8'h77, 1'b1, 78);
    chk("t5_overrun", bus.overrun, 0);
    chk("t5_count", bus.count, 16);
    chk("t5_head", bus.rdata, 8'h21);
    for (int i = 1; i < 16; i++) pop(8'h20 + i[7:0], "t5_pop");
    pop(8'h77, "t5_tail");
    chk("t5_count_after", bus.count, 0);

    send(8'h99, 1'b1, -1);
    chk("t6_count_pre", bus.count, 1);
    rxd = 1'b0;
    tick(30);
    rst = 1'b1;
    tick(3);
    chk("t6_rst_count", bus.count, 0);
    chk("t6_rst_rvalid", bus.rvalid, 0);
    chk("t6_rst_rdata", bus.rdata, 8'h00);
    chk("t6_rst_flags", {bus.overrun, bus.frame_err}, 0);
    rst = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(30);
    chk("t6_idle_count", bus.count, 0);
    chk("t6_idle_flags", {bus.overrun, bus.frame_err}, 0);
    send(8'h81, 1'b1, -1);
    chk("t6_count", bus.count, 1);
    chk("t6_rdata", bus.rdata, 8'h81);
    chk("t6_flags", {bus.overrun, bus.frame_err}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
